// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: op codes, chunk relation, FSM states.
// Also holds the helpers that decode signedness and the final op outcome.
package cmp_pkg;

  typedef enum logic [2:0] {
    OP_LT  = 3'd0,
    OP_LTU = 3'd1,
    OP_LE  = 3'd2,
    OP_LEU = 3'd3,
    OP_EQ  = 3'd4,
    OP_NE  = 3'd5,
    OP_GE  = 3'd6,
    OP_GEU = 3'd7
  } cmp_op_e;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_LT = 2'd1,
    REL_GT = 2'd2
  } cmp_rel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  function automatic logic is_signed(input cmp_op_e op);
    return (op == OP_LT) || (op == OP_LE) || (op == OP_GE);
  endfunction

  function automatic logic op_outcome(input cmp_op_e op, input cmp_rel_e rel);
    logic res;
    res = 1'b0;
    case (op)
      OP_LT, OP_LTU: res = (rel == REL_LT);
      OP_LE, OP_LEU: res = (rel != REL_GT);
      OP_EQ:         res = (rel == REL_EQ);
      OP_NE:         res = (rel != REL_EQ);
      OP_GE, OP_GEU: res = (rel != REL_LT);
      default:       res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Unsigned CHUNK-bit compare of one operand slice; purely combinational, no handshake.
module cmp_chunk
  import cmp_pkg::*;
#(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output cmp_rel_e         rel
);

  always_comb begin
    if (a < b)      rel = REL_LT;
    else if (a > b) rel = REL_GT;
    else            rel = REL_EQ;
  end

endmodule

// File: rtl/cmp_seq.sv
// Multi-cycle signed/unsigned comparator walking CHUNK bits per cycle from the MSB; result after WIDTH/CHUNK cycles.
// Valid/ready on both sides; a held result blocks new requests until consumed, with same-edge reissue.
module cmp_seq
  import cmp_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("cmp_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  cmp_state_e       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  cmp_rel_e         rel_q, rel_d;
  cmp_op_e          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

  logic             accept;
  logic [WIDTH-1:0] sign_flip;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  cmp_rel_e         chunk_rel, rel_next;

  assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  // Inverting the MSB maps two's-complement order onto unsigned order.
  assign sign_flip = {is_signed(cmp_op_e'(op)), {(WIDTH-1){1'b0}}};

  assign a_chunk = CHUNK'(a_q >> (CHUNK * int'(idx_q)));
  assign b_chunk = CHUNK'(b_q >> (CHUNK * int'(idx_q)));

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a   (a_chunk),
    .b   (b_chunk),
    .rel (chunk_rel)
  );

  // The first differing chunk from the MSB decides; later chunks cannot override it.
  assign rel_next = (rel_q == REL_EQ) ? chunk_rel : rel_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rel_d       = rel_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    gt_d        = gt_q;

    case (state_q)
      BUSY: begin
        rel_d = rel_next;
        if (idx_q == '0) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = {{(WIDTH-1){1'b0}}, op_outcome(op_q, rel_next)};
          lt_d        = (rel_next == REL_LT);
          eq_d        = (rel_next == REL_EQ);
          gt_d        = (rel_next == REL_GT);
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (accept) begin
      state_d = BUSY;
      idx_d   = IDXW'(NCHUNK - 1);
      rel_d   = REL_EQ;
      op_d    = cmp_op_e'(op);
      a_d     = a ^ sign_flip;
      b_d     = b ^ sign_flip;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rel_q       <= REL_EQ;
      op_q        <= OP_LT;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rel_q       <= rel_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      gt_q        <= gt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign gt        = gt_q;

endmodule

// File: tb/tb_cmp_seq.sv
// Directed table of hand-computed compares plus backpressure, async-reset and randomised sequences
// for cmp_seq at WIDTH=6, CHUNK=2.
module tb_cmp_seq;

  localparam int WIDTH  = 6;
  localparam int CHUNK  = 2;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [2:0]       op = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             lt, eq, gt;

  int checks = 0;
  int errors = 0;

  cmp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .lt        (lt),
    .eq        (eq),
    .gt        (gt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic [WIDTH-1:0] res;
    logic [2:0]       flags;  // {lt, eq, gt}
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference: native signed/unsigned compare, then op decode.
  function automatic logic [3:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                       input logic [2:0] mop);
    logic s, l, g, e, r;
    s = (mop == 3'd0) || (mop == 3'd2) || (mop == 3'd6);
    if (s) begin
      l = $signed(ma) < $signed(mb);
      g = $signed(ma) > $signed(mb);
    end else begin
      l = ma < mb;
      g = ma > mb;
    end
    e = (ma == mb);
    case (mop)
      3'd0, 3'd1: r = l;
      3'd2, 3'd3: r = !g;
      3'd4:       r = e;
      3'd5:       r = !e;
      default:    r = !l;
    endcase
    return {r, l, e, g};
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic [2:0] iop, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    a = ia; b = ib; op = iop; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t vecs[13];
  int   lat;
  logic [3:0] m;
  logic seen_valid;

  initial begin
    vecs[0]  = '{6'b111101, 6'b000010, 3'd0, 6'd1, 3'b100};  // -3 <  2
    vecs[1]  = '{6'b111101, 6'b111011, 3'd0, 6'd0, 3'b001};  // -3 <  -5
    vecs[2]  = '{6'b111101, 6'b111011, 3'd1, 6'd0, 3'b001};  // 61 <u 59
    vecs[3]  = '{6'b111101, 6'b111011, 3'd6, 6'd1, 3'b001};  // -3 >= -5
    vecs[4]  = '{6'b100000, 6'b100000, 3'd4, 6'd1, 3'b010};
    vecs[5]  = '{6'b100000, 6'b100000, 3'd2, 6'd1, 3'b010};
    vecs[6]  = '{6'b100000, 6'b100000, 3'd0, 6'd0, 3'b010};
    vecs[7]  = '{6'b100000, 6'b100000, 3'd5, 6'd0, 3'b010};
    vecs[8]  = '{6'b011111, 6'b100000, 3'd6, 6'd1, 3'b001};  // 31 >= -32
    vecs[9]  = '{6'b011111, 6'b100000, 3'd7, 6'd0, 3'b100};  // 31 >=u 32
    vecs[10] = '{6'b100000, 6'b000001, 3'd0, 6'd1, 3'b100};  // most negative
    vecs[11] = '{6'b000000, 6'b111111, 3'd3, 6'd1, 3'b100};
    vecs[12] = '{6'b111111, 6'b000000, 3'd3, 6'd0, 3'b001};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", {26'd0, result}, 32'd0);
    chk("reset_flags", {29'd0, lt, eq, gt}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, lat);
      chk($sformatf("vec%0d_latency", i), lat, NCHUNK);
      chk($sformatf("vec%0d_result", i), {26'd0, result}, {26'd0, vecs[i].res});
      chk($sformatf("vec%0d_flags", i), {29'd0, lt, eq, gt}, {29'd0, vecs[i].flags});
      consume();
    end

    // Backpressure: result held, no accept, then same-edge reissue.
    run_op(6'b111101, 6'b000010, 3'd0, lat);
    chk("bp_first_latency", lat, NCHUNK);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = a ^ 6'b111111;
      @(posedge clk); #1;
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
      chk("bp_result_held", {26'd0, result}, 32'd1);
    end
    a = 6'b000011; b = 6'b000010; op = 3'd7; out_ready = 1'b1;
    #1;
    chk("bp_in_ready_on_consume", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp_out_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("bp_busy_not_ready", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_second_latency", lat, NCHUNK);
    chk("bp_second_result", {26'd0, result}, 32'd1);
    chk("bp_second_flags", {29'd0, lt, eq, gt}, 32'b001);
    consume();

    // Async reset while BUSY at idx=1.
    a = 6'b000001; b = 6'b000010; op = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy_result", {26'd0, result}, 32'd0);
    chk("rst_busy_flags", {29'd0, lt, eq, gt}, 32'd0);
    chk("rst_busy_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      seen_valid = seen_valid | out_valid;
    end
    chk("rst_no_valid_pulse", {31'd0, seen_valid}, 32'd0);
    chk("rst_idle_ready", {31'd0, in_ready}, 32'd1);

    // Randomised ops against the reference, with random consumer stalls.
    for (int i = 0; i < 300; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic [2:0]       rop;
      ra  = WIDTH'($urandom);
      rb  = (i % 5 == 0) ? ra : WIDTH'($urandom);
      rop = 3'($urandom_range(0, 7));
      run_op(ra, rb, rop, lat);
      m = model(ra, rb, rop);
      chk("rand_latency", lat, NCHUNK);
      chk("rand_result", {26'd0, result}, {31'd0, m[3]});
      chk("rand_flags", {29'd0, lt, eq, gt}, {29'd0, m[2:0]});
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      consume();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
